fifo_wr_arbiter: RTL and testbench

- Shares the single write port of main_fifo between NUM_REQ producers using round-robin arbitration.
- Drives main_fifo en_write and in from registered outputs.
- Keeps a shadow occupancy count so it never writes into a full FIFO, despite the one-cycle lag on the full flag.
- Sits directly in front of main_fifo. The read side stays with the consumer; the arbiter only observes it.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helper for the main_fifo write arbiter.
// Feature macro used by the top: FIFO_WR_ARB_PRIO_EN.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_DATA_SIZE  = 8;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int get_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after rr_ptr.
// Wraps modulo N; valid is low when nothing is eligible.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = get_width(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] rr_ptr,
  output logic          valid,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [PW-1:0] j;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    j      = '0;
    for (int k = 1; k <= N; k++) begin
      j = PW'((int'(rr_ptr) + k) % N);
      if (!valid && elig[j]) begin
        valid     = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with shadow occupancy for main_fifo.
// Define FIFO_WR_ARB_PRIO_EN to make requester 0 fixed top priority.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  localparam int DATA_SIZE_WIDTH = get_width(DATA_SIZE),
  localparam int OW = DATA_SIZE_WIDTH + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_en_read,
  output logic                          fifo_en_write,
  output logic [DATA_WIDTH-1:0]         fifo_in,
  output logic [OW-1:0]                 occ
);

  localparam int PW = get_width(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] elig_rr;
  logic               win0;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               rd_fire;
  logic [OW-1:0]      occ_next;
  logic               issue;
  logic [PW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               ptr_upd;

  // Last cycle's winner sits out one cycle.
  assign elig = req & ~gnt;

`ifdef FIFO_WR_ARB_PRIO_EN
  assign win0    = elig[0];
  assign elig_rr = elig & ~NUM_REQ'(1);
`else
  assign win0    = 1'b0;
  assign elig_rr = elig;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .elig   (elig_rr),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  assign rd_fire  = fifo_en_read & (occ != '0);
  assign occ_next = occ + OW'(fifo_en_write) - OW'(rd_fire);

  always_comb begin
    win_idx = pick_idx;
    win_oh  = pick_oh;
    ptr_upd = 1'b1;
    if (win0) begin
      win_idx = '0;
      win_oh  = NUM_REQ'(1);
      ptr_upd = 1'b0;
    end
    issue = (win0 | pick_valid)
          & (occ_next < OW'(DATA_SIZE))
          & ~fifo_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt           <= '0;
      fifo_en_write <= 1'b0;
      fifo_in       <= '0;
      occ           <= '0;
      rr_ptr        <= PW'(NUM_REQ - 1);
    end else begin
      occ <= occ_next;
      if (issue) begin
        gnt           <= win_oh;
        fifo_en_write <= 1'b1;
        fifo_in       <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
        if (ptr_upd) rr_ptr <= win_idx;
      end else begin
        gnt           <= '0;
        fifo_en_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural main_fifo count.
// Honours FIFO_WR_ARB_PRIO_EN for the priority sequence.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_en_read;
  logic        fifo_en_write;
  logic [3:0]  fifo_in;
  logic [3:0]  occ;

  int compared = 0;
  int mismatched = 0;
  int fifo_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (4),
    .DATA_SIZE  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_full     (fifo_full),
    .fifo_en_read  (fifo_en_read),
    .fifo_en_write (fifo_en_write),
    .fifo_in       (fifo_in),
    .occ           (occ)
  );

  always #5 clk = ~clk;

  // main_fifo stand-in: full flag follows the stored count.
  always @(posedge clk) begin
    if (rst) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + int'(fifo_en_write)
                   - int'(fifo_en_read && fifo_cnt != 0);
  end
  assign fifo_full = (fifo_cnt >= 8);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && fifo_en_write)
      chk("wr_while_full", 32'(fifo_full), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_seq [6];
    rst = 1'b1;
    req = 4'b1111;
    req_data = 16'hDCBA;
    fifo_en_read = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr", 32'(fifo_en_write), 32'h0);
    chk("rst_occ", 32'(occ), 32'h0);
    chk("rst_in", 32'(fifo_in), 32'h0);

    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      chk("fair_in", 32'(fifo_in), 32'(4'hA + k % 4));
      chk("fair_occ", 32'(occ), 32'(k));
    end

    rst = 1'b1;
    tick();
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_wr", 32'(fifo_en_write), 32'h0);
    chk("midrst_occ", 32'(occ), 32'h0);

    rst = 1'b0;
    req = 4'b1100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("fill_gnt", 32'(gnt), (k % 2 == 1) ? 32'h4 : 32'h8);
      chk("fill_wr", 32'(fifo_en_write), 32'h1);
      chk("fill_occ", 32'(occ), 32'(k - 1));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_wr", 32'(fifo_en_write), 32'h0);
      chk("full_occ", 32'(occ), 32'h8);
    end

    fifo_en_read = 1'b1;
    tick();
    fifo_en_read = 1'b0;
    chk("rd_occ", 32'(occ), 32'h7);
    chk("rd_wr", 32'(fifo_en_write), 32'h0);
    tick();
    chk("refill_wr", 32'(fifo_en_write), 32'h1);
    chk("refill_gnt", 32'(gnt), 32'h4);
    chk("refill_in", 32'(fifo_in), 32'hC);
    chk("refill_occ", 32'(occ), 32'h7);
    fifo_en_read = 1'b1;
    tick();
    fifo_en_read = 1'b0;
    chk("rdwr_wr", 32'(fifo_en_write), 32'h1);
    chk("rdwr_gnt", 32'(gnt), 32'h8);
    chk("rdwr_in", 32'(fifo_in), 32'hD);
    chk("rdwr_occ", 32'(occ), 32'h7);
    tick();
    chk("refull_wr", 32'(fifo_en_write), 32'h0);
    chk("refull_occ", 32'(occ), 32'h8);

    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    fifo_en_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("empty_occ", 32'(occ), 32'h0);
      chk("empty_wr", 32'(fifo_en_write), 32'h0);
    end
    fifo_en_read = 1'b0;

`ifdef FIFO_WR_ARB_PRIO_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
`endif
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("prio_gnt", 32'(gnt), 32'(exp_seq[k]));
      chk("prio_occ", 32'(occ), 32'(k));
    end
    req = 4'b0000;
    tick();
    chk("idle_wr", 32'(fifo_en_write), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
